// File: rtl/fan_pkg.sv
// Shared constants, duty clamp and per-channel tach record for the fan controller.
// Purely declarative; no logic, latency or flow control of its own.
package fan_pkg;

   localparam int CLK_HZ        = 25_000_000;
   localparam int PWM_HZ        = 25_000;
   localparam int TACH_BITS_MAX = 16;

   typedef struct packed {
      logic [TACH_BITS_MAX-1:0] count;
      logic                     stall;
   } tach_rec_t;

   // Zero means off; anything else below the floor is raised so the fan still spins.
   function automatic logic [15:0] clamp_duty(input logic [15:0] duty,
                                              input logic [15:0] min_duty);
      if (duty == 16'd0) begin
         return 16'd0;
      end else if (duty < min_duty) begin
         return min_duty;
      end else begin
         return duty;
      end
   endfunction

endpackage

// File: rtl/fan_tach_ch.sv
// One tach channel: 2-flop synchroniser, level debounce and saturating falling-edge counter.
// Latency: input edge to count is 2 + TACH_DEB + 1 clocks; counter clears on win_wrap.
// Backpressure: none, the count is sampled by the parent at each window wrap.
module fan_tach_ch #(
   parameter int TACH_DEB  = 16,
   parameter int TACH_BITS = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tach_i,
   input  logic                 win_wrap,
   output logic [TACH_BITS-1:0] edge_cnt_o
);

   localparam int DB_W = $clog2(TACH_DEB + 1);

   logic                 sync1_q, sync2_q;
   logic                 lvl_q, lvl_d;
   logic [DB_W-1:0]      deb_q, deb_d;
   logic [TACH_BITS-1:0] cnt_q, cnt_d;
   logic                 fall;

   always_comb begin
      lvl_d = lvl_q;
      deb_d = '0;
      if (sync2_q != lvl_q) begin
         if (deb_q == DB_W'(TACH_DEB - 1)) begin
            lvl_d = sync2_q;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end
      fall = lvl_q & ~lvl_d;
      // An edge landing on the wrap cycle belongs to the window that starts there.
      if (win_wrap) begin
         cnt_d = TACH_BITS'(fall);
      end else if (fall && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         lvl_q   <= 1'b0;
         deb_q   <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= tach_i;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign edge_cnt_o = cnt_q;

endmodule

// File: rtl/fan_ctrl_mc.sv
// Multi-channel fan PWM generator with windowed tach counting and stall flags; FAN_FAILSAFE_EN adds a watchdog that forces full speed.
// Latency: duty write visible on duty_o after 1 clock, on pwm_o from the next period; tach_upd_o 1 clock after window wrap.
// Backpressure: none, writes are always accepted (out-of-range channel writes dropped).
module fan_ctrl_mc
   import fan_pkg::*;
#(
   parameter int NUM_CH       = 3,
   parameter int PWM_BITS     = 8,
   parameter int PWM_PERIOD   = CLK_HZ / PWM_HZ,
   parameter int MIN_DUTY     = 51,
   parameter int RST_DUTY     = (1 << PWM_BITS) - 1,
   parameter int TACH_DEB     = 16,
   parameter int TACH_WIN_CYC = CLK_HZ,
   parameter int TACH_BITS    = 12,
   parameter int STALL_MIN    = 2,
   parameter int WDOG_WIN     = 4,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          CPLD_CLK_25M,
   input  logic                          CPLD_RST,
   input  logic                          wr_en,
   input  logic [CH_W-1:0]               wr_ch,
   input  logic [PWM_BITS-1:0]           wr_duty,
   input  logic [NUM_CH-1:0]             tach_i,
   output logic [NUM_CH-1:0]             pwm_o,
   output logic [NUM_CH*PWM_BITS-1:0]    duty_o,
   output logic [NUM_CH*TACH_BITS-1:0]   tach_cnt_o,
   output logic                          tach_upd_o,
   output logic [NUM_CH-1:0]             stall_o,
   output logic                          fail_o
);

   localparam int PC_W  = $clog2(PWM_PERIOD);
   localparam int WC_W  = $clog2(TACH_WIN_CYC);
   localparam int MUL_W = PWM_BITS + PC_W;
   localparam logic [TACH_BITS_MAX-1:0] CNT_MAX = TACH_BITS_MAX'((1 << TACH_BITS) - 1);

   logic [PC_W-1:0]      pwm_cnt_q, pwm_cnt_d;
   logic [WC_W-1:0]      win_cnt_q, win_cnt_d;
   logic                 pwm_wrap, win_wrap, wr_acc;
   logic                 upd_q, upd_d;
   logic                 force_pwm;
   logic [PWM_BITS-1:0]  duty_q [NUM_CH];
   logic [PWM_BITS-1:0]  duty_d [NUM_CH];
   logic [PWM_BITS-1:0]  per_duty_q [NUM_CH];
   logic [PWM_BITS-1:0]  per_duty_d [NUM_CH];
   tach_rec_t            rec_q [NUM_CH];
   tach_rec_t            rec_d [NUM_CH];
   logic [TACH_BITS-1:0] edge_cnt [NUM_CH];
   logic [NUM_CH-1:0]    pwm_q, pwm_d, stall_d;
   logic [MUL_W-1:0]     prod_v, thr_v;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_tach
      fan_tach_ch #(
         .TACH_DEB  (TACH_DEB),
         .TACH_BITS (TACH_BITS)
      ) u_tach (
         .clk        (CPLD_CLK_25M),
         .rst        (CPLD_RST),
         .tach_i     (tach_i[ch]),
         .win_wrap   (win_wrap),
         .edge_cnt_o (edge_cnt[ch])
      );
   end

   always_comb begin
      pwm_wrap  = (pwm_cnt_q == PC_W'(PWM_PERIOD - 1));
      win_wrap  = (win_cnt_q == WC_W'(TACH_WIN_CYC - 1));
      pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
      win_cnt_d = win_wrap ? '0 : win_cnt_q + 1'b1;
      upd_d     = win_wrap;
      wr_acc    = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH));
      prod_v    = '0;
      thr_v     = '0;
      pwm_d     = '0;
      stall_d   = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         duty_d[ch] = duty_q[ch];
         if (wr_acc && (wr_ch == CH_W'(ch))) begin
            duty_d[ch] = PWM_BITS'(clamp_duty(16'(wr_duty), 16'(MIN_DUTY)));
         end
         // Duty is only sampled at the period boundary, so no runt pulses.
         per_duty_d[ch] = pwm_wrap ? duty_d[ch] : per_duty_q[ch];
         prod_v    = MUL_W'(per_duty_d[ch]) * MUL_W'(PWM_PERIOD);
         thr_v     = prod_v >> PWM_BITS;
         pwm_d[ch] = force_pwm || (per_duty_d[ch] == '1) || (MUL_W'(pwm_cnt_d) < thr_v);

         rec_d[ch] = rec_q[ch];
         if (win_wrap) begin
            rec_d[ch].count = TACH_BITS_MAX'(edge_cnt[ch]);
            rec_d[ch].stall = (edge_cnt[ch] < TACH_BITS'(STALL_MIN));
         end
         if (duty_d[ch] == '0) begin
            rec_d[ch].stall = 1'b0;
         end
         stall_d[ch] = rec_d[ch].stall;
      end
   end

   always_ff @(posedge CPLD_CLK_25M) begin
      if (CPLD_RST) begin
         pwm_cnt_q <= '0;
         win_cnt_q <= '0;
         upd_q     <= 1'b0;
         pwm_q     <= '1;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            duty_q[ch]     <= PWM_BITS'(RST_DUTY);
            per_duty_q[ch] <= PWM_BITS'(RST_DUTY);
            rec_q[ch]      <= '0;
         end
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         win_cnt_q <= win_cnt_d;
         upd_q     <= upd_d;
         pwm_q     <= pwm_d;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            duty_q[ch]     <= duty_d[ch];
            per_duty_q[ch] <= per_duty_d[ch];
            rec_q[ch]      <= rec_d[ch];
         end
      end
   end

`ifdef FAN_FAILSAFE_EN
   localparam int WD_W = $clog2(WDOG_WIN + 1);

   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            fail_q, fail_d;

   always_comb begin
      wdog_d = wdog_q;
      if (wr_acc) begin
         wdog_d = '0;
      end else if (win_wrap && (wdog_q != WD_W'(WDOG_WIN))) begin
         wdog_d = wdog_q + 1'b1;
      end
      // Sets as soon as a cause appears; only a clean window end releases it.
      if ((|stall_d) || (wdog_d == WD_W'(WDOG_WIN))) begin
         fail_d = 1'b1;
      end else if (win_wrap) begin
         fail_d = 1'b0;
      end else begin
         fail_d = fail_q;
      end
   end

   always_ff @(posedge CPLD_CLK_25M) begin
      if (CPLD_RST) begin
         wdog_q <= '0;
         fail_q <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         fail_q <= fail_d;
      end
   end

   assign force_pwm = fail_q;
   assign fail_o    = fail_q;
`else
   assign force_pwm = 1'b0;
   assign fail_o    = 1'b0;
`endif

   always_comb begin
      duty_o     = '0;
      tach_cnt_o = '0;
      stall_o    = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         duty_o[ch*PWM_BITS +: PWM_BITS] = duty_q[ch];
         tach_cnt_o[ch*TACH_BITS +: TACH_BITS] =
            (rec_q[ch].count > CNT_MAX) ? '1 : rec_q[ch].count[TACH_BITS-1:0];
         stall_o[ch] = rec_q[ch].stall;
      end
   end

   assign pwm_o      = pwm_q;
   assign tach_upd_o = upd_q;

endmodule
